// File: rtl/shared_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shared_bus_arb_pkg
//  Brief    : Shared types and default parameters for shared_bus_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package shared_bus_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_t;

  localparam int ARB_N_DEFAULT        = 4;
  localparam int ARB_W_DEFAULT        = 32;
  localparam int ARB_TURN_DEFAULT     = 1;
  localparam int ARB_MAX_HOLD_DEFAULT = 8;

endpackage : shared_bus_arb_pkg
`default_nettype wire

// File: rtl/shared_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Brief    : Combinational round-robin picker. Selects the first set request
//             bit at or after rr_ptr, wrapping modulo N.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import shared_bus_arb_pkg::*;
#(
  parameter int N = ARB_N_DEFAULT
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx,
  output logic [N-1:0]         onehot
);

  localparam int IW = $clog2(N);
  // One extra bit so ptr + offset never overflows before the wrap
  localparam logic [IW:0] N_EXT = (IW+1)'(N);

  logic [IW:0]   cand_sum;
  logic [IW-1:0] cand;

  // Scan offsets 0..N-1 from the pointer; the first requester found wins
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    onehot   = '0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      cand_sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand_sum >= N_EXT) begin
        cand_sum = cand_sum - N_EXT;
      end
      cand = cand_sum[IW-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    onehot[idx] = found;
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/shared_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : shared_bus_arbiter
//  Brief    : Round-robin owner arbitration for one shared W-bit net with a
//             guaranteed all-grants-low turnaround gap between owners.
//             Optional owner hold limit under SHARED_BUS_ARB_HOLD_LIMIT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module shared_bus_arbiter
  import shared_bus_arb_pkg::*;
#(
  parameter int N           = ARB_N_DEFAULT,
  parameter int W           = ARB_W_DEFAULT,
  parameter int TURN_CYCLES = ARB_TURN_DEFAULT
`ifdef SHARED_BUS_ARB_HOLD_LIMIT_EN
  , parameter int MAX_HOLD  = ARB_MAX_HOLD_DEFAULT
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       data_in,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         drv_en,
  output logic [$clog2(N)-1:0] owner_id,
  output logic [W-1:0]         bus_out,
  output logic                 bus_valid,
  output logic                 turnaround
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TURN_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES);
  localparam logic [TW-1:0] TURN_LAST = TW'(1);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [TW-1:0] turn_q, turn_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;
  logic          owner_done;
  logic [IW-1:0] owner_next;

  rr_pick #(.N(N)) u_pick (
    .req    (req),
    .rr_ptr (ptr_q),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Pointer moves just past the releasing owner, wrapping N-1 -> 0
  assign owner_next = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

`ifdef SHARED_BUS_ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  logic [HW-1:0] hold_q, hold_d;

  // Owner leaves on voluntary drop, or when its hold budget is spent under contention
  assign owner_done = !req[owner_q] ||
                      ((hold_q == HOLD_MAX) && (|(req & ~grant_q)));
`else
  // Owner leaves only by dropping its request
  assign owner_done = !req[owner_q];
`endif

  // Next-state, grant, pointer and counter computation
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    turn_d  = turn_q;
`ifdef SHARED_BUS_ARB_HOLD_LIMIT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_GRANT;
          grant_d = pick_onehot;
          owner_d = pick_idx;
`ifdef SHARED_BUS_ARB_HOLD_LIMIT_EN
          hold_d  = HW'(1);
`endif
        end
      end
      ARB_GRANT: begin
        if (owner_done) begin
          state_d = ARB_TURN;
          grant_d = '0;
          ptr_d   = owner_next;
          turn_d  = TURN_LOAD;
        end
`ifdef SHARED_BUS_ARB_HOLD_LIMIT_EN
        else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      ARB_TURN: begin
        if (turn_q == TURN_LAST) begin
          if (pick_found) begin
            state_d = ARB_GRANT;
            grant_d = pick_onehot;
            owner_d = pick_idx;
`ifdef SHARED_BUS_ARB_HOLD_LIMIT_EN
            hold_d  = HW'(1);
`endif
          end else begin
            state_d = ARB_IDLE;
          end
        end else begin
          turn_d = turn_q - 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      turn_q  <= '0;
`ifdef SHARED_BUS_ARB_HOLD_LIMIT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      turn_q  <= turn_d;
`ifdef SHARED_BUS_ARB_HOLD_LIMIT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  // Owner's value onto the bus when granted, zero otherwise
  always_comb begin
    bus_out = '0;
    if (bus_valid) begin
      bus_out = data_in[owner_q*W +: W];
    end
  end

  assign grant      = grant_q;
  assign drv_en     = grant_q;
  assign owner_id   = owner_q;
  assign bus_valid  = |grant_q;
  assign turnaround = (state_q == ARB_TURN);

endmodule : shared_bus_arbiter
`default_nettype wire

// File: tb/tb_shared_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shared_bus_arbiter
//  Brief    : Directed self-checking bench for shared_bus_arbiter
//             (N=4, W=32, TURN_CYCLES=1, MAX_HOLD=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shared_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] data_in;
  logic [3:0]   grant;
  logic [3:0]   drv_en;
  logic [1:0]   owner_id;
  logic [31:0]  bus_out;
  logic         bus_valid;
  logic         turnaround;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] dval [4];

  shared_bus_arbiter #(.N(4), .W(32), .TURN_CYCLES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .data_in    (data_in),
    .grant      (grant),
    .drv_en     (drv_en),
    .owner_id   (owner_id),
    .bus_out    (bus_out),
    .bus_valid  (bus_valid),
    .turnaround (turnaround)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Owner cycle: grant one-hot, drive enables, id and muxed data
  task automatic chk_owner(input string tag, input int o);
    logic [3:0] oh;
    oh = 4'b0001 << o;
    chk({tag, "_grant"}, {28'd0, grant}, {28'd0, oh});
    chk({tag, "_drv"}, {28'd0, drv_en}, {28'd0, oh});
    chk({tag, "_id"}, {30'd0, owner_id}, 32'(o));
    chk({tag, "_bus"}, bus_out, dval[o]);
    chk({tag, "_valid"}, {31'd0, bus_valid}, 32'd1);
    chk({tag, "_turn"}, {31'd0, turnaround}, 32'd0);
  endtask

  // No owner: everything low, turnaround as given
  task automatic chk_empty(input string tag, input logic exp_turn);
    chk({tag, "_grant"}, {28'd0, grant}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus_valid}, 32'd0);
    chk({tag, "_bus"}, bus_out, 32'd0);
    chk({tag, "_turn"}, {31'd0, turnaround}, {31'd0, exp_turn});
  endtask

  // Reset, make agent 1 the owner, release it, then present req_turn in TURN
  task automatic turn_case(input string tag, input logic [3:0] req_turn, input int exp_o);
    rst = 1'b1; req = 4'b0000; tick();
    rst = 1'b0; req = 4'b0010; tick();
    chk_owner({tag, "_own1"}, 1);
    req = 4'b0000; tick();
    chk_empty({tag, "_gap"}, 1'b1);
    req = req_turn; tick();
    chk_owner({tag, "_win"}, exp_o);
  endtask

  initial begin
    dval[0] = 32'h1111_1111;
    dval[1] = 32'h2222_2222;
    dval[2] = 32'hdead_beef;
    dval[3] = 32'h4444_4444;
    data_in = {dval[3], dval[2], dval[1], dval[0]};

    // 1. Reset with all requesting, then agent 0 first
    rst = 1'b1; req = 4'b1111;
    tick(); tick();
    chk_empty("rst", 1'b0);
    chk("rst_id", {30'd0, owner_id}, 32'd0);
    chk("rst_drv", {28'd0, drv_en}, 32'd0);
    rst = 1'b0;
    tick();
    chk_owner("post_rst", 0);
    req = 4'b0000; tick();
    chk_empty("t1_turn", 1'b1);
    tick();
    chk_empty("t1_idle", 1'b0);

    // 2. Agent 2 alone
    req = 4'b0100; tick();
    chk_owner("a2", 2);
    tick();
    chk_owner("a2_hold", 2);
    req = 4'b0000; tick();
    chk_empty("a2_turn", 1'b1);
    tick();
    chk_empty("a2_idle", 1'b0);

    // 3. Full contention, each owner holds 3 cycles; order 0,1,2,3,0
    rst = 1'b1; req = 4'b0000; tick();
    rst = 1'b0; req = 4'b1111;
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      for (int s = 0; s < 5; s++) begin
        tick();
        chk_owner($sformatf("rr%0d_c1", s), order[s]);
        tick();
        chk_owner($sformatf("rr%0d_c2", s), order[s]);
        tick();
        chk_owner($sformatf("rr%0d_c3", s), order[s]);
        req = 4'b1111 & ~(4'b0001 << order[s]);
        tick();
        chk_empty($sformatf("rr%0d_gap", s), 1'b1);
        req = (s == 4) ? 4'b0000 : 4'b1111;
      end
    end
    tick();
    chk_empty("rr_idle", 1'b0);

    // 4. Agent 0 never drops while agent 1 waits (pointer currently at 1)
    req = 4'b0001; tick();
    chk_owner("hold_c1", 0);
    req = 4'b0011;
`ifdef SHARED_BUS_ARB_HOLD_LIMIT_EN
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk_owner($sformatf("hold_c%0d", c), 0);
    end
    tick();
    chk_empty("hold_forced_turn", 1'b1);
    tick();
    chk_owner("hold_next", 1);
`else
    for (int c = 2; c <= 50; c++) begin
      tick();
      chk_owner($sformatf("hold_c%0d", c), 0);
    end
    req = 4'b0010; tick();
    chk_empty("hold_rel_turn", 1'b1);
    tick();
    chk_owner("hold_next", 1);
`endif

    // 5. Reset while agent 3 owns the bus
    req = 4'b0000; tick();
    chk_empty("m_turn", 1'b1);
    tick();
    chk_empty("m_idle", 1'b0);
    req = 4'b1000; tick();
    chk_owner("m_own3", 3);
    req = 4'b1111; rst = 1'b1; tick();
    chk_empty("m_rst", 1'b0);
    chk("m_rst_id", {30'd0, owner_id}, 32'd0);
    rst = 1'b0; tick();
    chk_owner("m_after", 0);

    // 6. Former owner 1 re-requests during TURN with others
    turn_case("tc_2", 4'b1111, 2);
    turn_case("tc_3", 4'b1011, 3);
    turn_case("tc_0", 4'b0011, 0);
    turn_case("tc_1", 4'b0010, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog against a stalled run
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_shared_bus_arbiter
`default_nettype wire
